// File: rtl/seq_detect_param.sv
// Serial pattern detector with a loadable pattern, selectable overlapping or
// non-overlapping detection, and a saturating match counter.
module seq_detect_param #(
   parameter int unsigned      PAT_W   = 4,
   parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1101),
   parameter int unsigned      CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             x,
   input  logic             x_vld,
   input  logic [PAT_W-1:0] pat_in,
   input  logic             pat_ld,
   input  logic             ovl,
   input  logic             cnt_clr,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

   localparam int unsigned     FW   = $clog2(PAT_W + 1);
   localparam logic [FW-1:0]   FULL = FW'(PAT_W);

   typedef enum logic [1:0] {EMPTY, FILLING, ARMED} state_t;

   state_t             state_q, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d;
   logic [PAT_W-1:0]   hist_q, hist_d;
   logic [FW-1:0]      fill_q, fill_d;
   logic               match_q, match_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [PAT_W-1:0]   hist_shift;
   logic [FW-1:0]      fill_inc;
   logic               hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         pat_q   <= PAT_RST;
         hist_q  <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         match_q <= match_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      hist_shift = {hist_q[PAT_W-2:0], x};
      fill_inc   = (state_q == ARMED) ? FULL : fill_q + FW'(1);
      hit        = x_vld && !pat_ld && (fill_inc == FULL) && (hist_shift == pat_q);

      pat_d   = pat_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      match_d = 1'b0;

      if (pat_ld) begin
         pat_d  = pat_in;
         hist_d = '0;
         fill_d = '0;
      end else if (x_vld) begin
         hist_d  = hist_shift;
         match_d = hit;
         // Non-overlapping mode restarts the fill so no matched bit is reused.
         if (hit) fill_d = ovl ? FULL : '0;
         else     fill_d = fill_inc;
      end

      if (fill_d == '0)       state_d = EMPTY;
      else if (fill_d == FULL) state_d = ARMED;
      else                    state_d = FILLING;

      cnt_d = cnt_q;
      if (cnt_clr)                  cnt_d = '0;
      else if (hit && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   assign match     = match_q;
   assign match_cnt = cnt_q;
   assign cnt_sat   = &cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench: the driver queues the hand-computed post-edge outputs for
// each cycle and a negedge monitor pops and compares them against the DUTs.
module tb_seq_detect_param;

   typedef struct packed {
      logic       m;
      logic [7:0] cnt;
      logic       sat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       x, x_vld, pat_ld, ovl, cnt_clr;
   logic [3:0] pat_in;
   logic       match;
   logic [7:0] match_cnt;
   logic       cnt_sat;

   logic       x2, x_vld2, pat_ld2, ovl2, cnt_clr2;
   logic [1:0] pat_in2;
   logic       match2;
   logic [1:0] match_cnt2;
   logic       cnt_sat2;

   exp_t q1[$];
   exp_t q2[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   step_no = 0;
   string tname = "reset";

   always #5 clk = ~clk;

   seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1101), .CNT_W(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .x(x), .x_vld(x_vld), .pat_in(pat_in),
      .pat_ld(pat_ld), .ovl(ovl), .cnt_clr(cnt_clr), .match(match),
      .match_cnt(match_cnt), .cnt_sat(cnt_sat)
   );

   seq_detect_param #(.PAT_W(2), .PAT_RST(2'b11), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .x(x2), .x_vld(x_vld2), .pat_in(pat_in2),
      .pat_ld(pat_ld2), .ovl(ovl2), .cnt_clr(cnt_clr2), .match(match2),
      .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
   );

   always @(negedge clk) begin
      exp_t e;
      if (q1.size() > 0) begin
         e = q1.pop_front();
         n_chk++;
         if ({match, match_cnt, cnt_sat} !== e) begin
            n_fail++;
            $display("FAIL %s step %0d (dut1): got match=%b cnt=%0d sat=%b, expected match=%b cnt=%0d sat=%b",
                     tname, step_no, match, match_cnt, cnt_sat, e.m, e.cnt, e.sat);
         end
      end
      if (q2.size() > 0) begin
         e = q2.pop_front();
         n_chk++;
         if ({match2, match_cnt2, cnt_sat2} !== {e.m, e.cnt[1:0], e.sat}) begin
            n_fail++;
            $display("FAIL %s step %0d (dut2): got match=%b cnt=%0d sat=%b, expected match=%b cnt=%0d sat=%b",
                     tname, step_no, match2, match_cnt2, cnt_sat2, e.m, e.cnt[1:0], e.sat);
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic step1(input logic v, input logic xb, input logic ld, input logic [3:0] p,
                        input logic o, input logic c, input logic em, input logic [7:0] ec);
      x_vld = v; x = xb; pat_ld = ld; pat_in = p; ovl = o; cnt_clr = c;
      step_no++;
      @(posedge clk);
      q1.push_back('{m: em, cnt: ec, sat: 1'b0});
      @(negedge clk);
   endtask

   task automatic bit1(input logic xb, input logic o, input logic em, input logic [7:0] ec);
      step1(1'b1, xb, 1'b0, 4'h0, o, 1'b0, em, ec);
   endtask

   // Idle cycles drive x=1 so a detector that ignores x_vld would be caught.
   task automatic idle1(input logic [7:0] ec);
      step1(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, ec);
   endtask

   task automatic load1(input logic [3:0] p, input logic [7:0] ec);
      step1(1'b0, 1'b0, 1'b1, p, 1'b1, 1'b0, 1'b0, ec);
   endtask

   task automatic clr1();
      step1(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 8'd0);
   endtask

   task automatic step2(input logic v, input logic c, input logic em, input logic [1:0] ec,
                        input logic es);
      x_vld2 = v; x2 = 1'b1; cnt_clr2 = c;
      step_no++;
      @(posedge clk);
      q2.push_back('{m: em, cnt: {6'd0, ec}, sat: es});
      @(negedge clk);
   endtask

   initial begin
      x = 0; x_vld = 0; pat_ld = 0; pat_in = '0; ovl = 1; cnt_clr = 0;
      x2 = 0; x_vld2 = 0; pat_ld2 = 0; pat_in2 = '0; ovl2 = 1; cnt_clr2 = 0;
      #3;
      chk("reset match", {7'd0, match}, 8'd0);
      chk("reset cnt", match_cnt, 8'd0);
      chk("reset sat", {7'd0, cnt_sat}, 8'd0);
      chk("reset dut2 cnt", {6'd0, match_cnt2}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;

      tname = "overlap_1101"; step_no = 0;
      bit1(1, 1, 0, 0); bit1(1, 1, 0, 0); bit1(0, 1, 0, 0); bit1(1, 1, 1, 1);
      bit1(1, 1, 0, 1); bit1(0, 1, 0, 1); bit1(1, 1, 1, 2);
      idle1(2);
      load1(4'b1101, 2);
      clr1();

      tname = "nonoverlap_1101"; step_no = 0;
      bit1(1, 0, 0, 0); bit1(1, 0, 0, 0); bit1(0, 0, 0, 0); bit1(1, 0, 1, 1);
      bit1(1, 0, 0, 1); bit1(0, 0, 0, 1); bit1(1, 0, 0, 1);
      load1(4'b1101, 1);
      clr1();

      tname = "vld_gaps"; step_no = 0;
      bit1(1, 1, 0, 0); repeat (3) idle1(0);
      bit1(1, 1, 0, 0); repeat (3) idle1(0);
      bit1(0, 1, 0, 0); repeat (3) idle1(0);
      bit1(1, 1, 1, 1); repeat (3) idle1(1);
      load1(4'b1101, 1);
      clr1();

      tname = "pat_load"; step_no = 0;
      bit1(1, 1, 0, 0); bit1(1, 1, 0, 0); bit1(0, 1, 0, 0);
      step1(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 8'd0);
      bit1(0, 1, 0, 0); bit1(1, 1, 0, 0); bit1(1, 1, 0, 0); bit1(0, 1, 1, 1);
      bit1(1, 1, 0, 1); bit1(1, 1, 0, 1); bit1(0, 1, 1, 2);
      bit1(1, 1, 0, 2); bit1(1, 1, 0, 2);
      step1(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 8'd0);

      tname = "async_reset"; step_no = 0;
      load1(4'b0110, 0);
      bit1(0, 1, 0, 0); bit1(1, 1, 0, 0); bit1(1, 1, 0, 0); bit1(0, 1, 1, 1);
      load1(4'b0110, 1);
      bit1(1, 1, 0, 1); bit1(1, 1, 0, 1); bit1(0, 1, 0, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset cnt", match_cnt, 8'd0);
      chk("async reset match", {7'd0, match}, 8'd0);
      chk("async reset sat", {7'd0, cnt_sat}, 8'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bit1(1, 1, 0, 0); bit1(1, 1, 0, 0); bit1(0, 1, 0, 0); bit1(1, 1, 1, 1);

      tname = "saturate_cnt2"; step_no = 0;
      x_vld = 0; pat_ld = 0; cnt_clr = 0;
      step2(1, 0, 0, 2'd0, 0);
      step2(1, 0, 1, 2'd1, 0);
      step2(1, 0, 1, 2'd2, 0);
      step2(1, 0, 1, 2'd3, 1);
      step2(1, 0, 1, 2'd3, 1);
      step2(1, 0, 1, 2'd3, 1);
      step2(0, 1, 0, 2'd0, 0);

      #1;
      tname = "drain";
      chk("scoreboard drained", 8'(q1.size() + q2.size()), 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
      $fatal(1);
   end

endmodule
